// File: rtl/alu_seq.sv
// alu_seq: runs one wide (NBYTES x 8) operation through the shared 8-bit ALU,
// one byte pass per cycle. Carry/shift-out is chained between passes, and the
// per-byte flags are merged into whole-word flags. Requests and results use
// valid/ready handshakes. Only one operation is in flight at a time.
module alu_seq #(
  parameter int NBYTES = 2,
  localparam int W     = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [8:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic         req_ci,
  input  logic         req_msb_first,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_co,
  output logic         rsp_z,
  output logic         rsp_neg,
  output logic         busy,
  output logic [7:0]   alu_a_o,
  output logic [7:0]   alu_acc_o,
  output logic         alu_ci_o,
  output logic [8:0]   alu_op_o,
  input  logic [7:0]   alu_acc_i,
  input  logic         alu_co_i,
  input  logic         alu_z_i,
  input  logic         alu_neg_i
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [8:0]              op_q;
  logic [NBYTES-1:0][7:0]  a_q, b_q, res_q;
  logic                    ci_q, msb_q, carry_q, z_q, neg_q;
  logic [IW-1:0]           idx_q, byte_k;
  logic                    last_pass;

  // Byte handled in the current pass. MSB-first walks the bytes downward so
  // that right shifts can chain the shift-out bit toward the LSB.
  always_comb begin
    byte_k    = msb_q ? (LAST - idx_q) : idx_q;
    last_pass = (idx_q == LAST);
  end

  assign rsp_result = res_q;
  assign rsp_co     = carry_q;
  assign rsp_z      = z_q;
  assign rsp_neg    = neg_q;

  // Next-state logic, handshake outputs and ALU drive. The ALU inputs are
  // driven only during RUN and are held at zero otherwise.
  always_comb begin
    state_d   = state_q;
    req_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == DONE);
    alu_a_o   = '0;
    alu_acc_o = '0;
    alu_ci_o  = 1'b0;
    alu_op_o  = '0;
    case (state_q)
      IDLE: if (req_valid) state_d = RUN;
      RUN: begin
        alu_a_o   = a_q[byte_k];
        alu_acc_o = b_q[byte_k];
        alu_op_o  = op_q;
        alu_ci_o  = (idx_q == '0) ? ci_q : carry_q;
        if (last_pass) state_d = DONE;
      end
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the request, accumulate the per-pass results and flags, and apply
  // a synchronous reset that drops any operation in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ci_q    <= 1'b0;
      msb_q   <= 1'b0;
      carry_q <= 1'b0;
      z_q     <= 1'b0;
      neg_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (req_valid) begin
          op_q    <= req_op;
          a_q     <= req_a;
          b_q     <= req_b;
          ci_q    <= req_ci;
          msb_q   <= req_msb_first;
          res_q   <= '0;
          carry_q <= 1'b0;
          z_q     <= 1'b1;
          neg_q   <= 1'b0;
          idx_q   <= '0;
        end
        RUN: begin
          res_q[byte_k] <= alu_acc_i;
          carry_q       <= alu_co_i;
          z_q           <= z_q & alu_z_i;
          if (byte_k == LAST) neg_q <= alu_neg_i;
          idx_q         <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq with NBYTES=2. A byte-wide ALU model answers the DUT's ALU
// port. A word-level reference model predicts every response, and a negedge
// compare process checks each cycle that rsp_valid is high.
module tb_alu_seq;
  localparam int NB = 2;
  localparam int W  = 8 * NB;

  localparam logic [8:0] OP_ADD = 9'h001;
  localparam logic [8:0] OP_SHL = 9'h002;
  localparam logic [8:0] OP_SHR = 9'h003;
  localparam logic [8:0] OP_UNK = 9'h1A5;  // not a real opcode; ALU model XORs

  logic         clk = 1'b0, reset = 1'b0;
  logic         req_valid = 1'b0, req_ready;
  logic [8:0]   req_op = '0;
  logic [W-1:0] req_a = '0, req_b = '0;
  logic         req_ci = 1'b0, req_msb_first = 1'b0;
  logic         rsp_valid, rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic         rsp_co, rsp_z, rsp_neg, busy;
  logic [7:0]   alu_a_o, alu_acc_o, alu_acc_i;
  logic         alu_ci_o, alu_co_i, alu_z_i, alu_neg_i;
  logic [8:0]   alu_op_o;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         z;
    logic         neg;
  } rsp_t;

  int   checks = 0, errors = 0;
  rsp_t exp_rsp;
  bit   exp_have = 1'b0;

  always #5 clk = ~clk;

  alu_seq #(.NBYTES(NB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ci(req_ci), .req_msb_first(req_msb_first),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_co(rsp_co), .rsp_z(rsp_z), .rsp_neg(rsp_neg), .busy(busy),
    .alu_a_o(alu_a_o), .alu_acc_o(alu_acc_o), .alu_ci_o(alu_ci_o), .alu_op_o(alu_op_o),
    .alu_acc_i(alu_acc_i), .alu_co_i(alu_co_i), .alu_z_i(alu_z_i), .alu_neg_i(alu_neg_i)
  );

  // Byte-wide ALU standing in for the shared instance.
  always_comb begin
    alu_acc_i = alu_a_o ^ alu_acc_o;
    alu_co_i  = 1'b0;
    case (alu_op_o)
      OP_ADD: {alu_co_i, alu_acc_i} = {1'b0, alu_a_o} + {1'b0, alu_acc_o} + {8'd0, alu_ci_o};
      OP_SHL: {alu_co_i, alu_acc_i} = {alu_a_o, alu_ci_o};
      OP_SHR: begin alu_acc_i = {alu_ci_o, alu_a_o[7:1]}; alu_co_i = alu_a_o[0]; end
      default: ;
    endcase
    alu_z_i   = (alu_acc_i == 8'd0);
    alu_neg_i = alu_acc_i[7];
  end

  // Whole-word reference: what the wide operation must produce.
  function automatic rsp_t ref_op(logic [8:0] op, logic [W-1:0] a, logic [W-1:0] b, logic ci);
    rsp_t r;
    r.co = 1'b0;
    case (op)
      OP_ADD: {r.co, r.res} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      OP_SHL: {r.co, r.res} = {a, ci};
      OP_SHR: begin r.res = {ci, a[W-1:1]}; r.co = a[0]; end
      default: r.res = a ^ b;
    endcase
    r.z   = (r.res == '0);
    r.neg = r.res[W-1];
    return r;
  endfunction

  // Every cycle a response is presented, it must match the reference.
  always @(negedge clk) begin
    if (rsp_valid) begin
      checks++;
      if (!exp_have || {rsp_result, rsp_co, rsp_z, rsp_neg} !== exp_rsp) begin
        errors++;
        $display("FAIL rsp_cmp act res=%h co=%b z=%b neg=%b exp res=%h co=%b z=%b neg=%b pending=%0d",
                 rsp_result, rsp_co, rsp_z, rsp_neg, exp_rsp.res, exp_rsp.co, exp_rsp.z,
                 exp_rsp.neg, exp_have);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return one cycle after acceptance (pass 0 visible).
  // The request fields are then scrambled to show they were latched.
  task automatic issue(input logic [8:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic msb);
    int n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk("issue_ready", req_ready, 1);
    req_op = op; req_a = a; req_b = b; req_ci = ci; req_msb_first = msb;
    req_valid = 1'b1;
    exp_rsp  = ref_op(op, a, b, ci);
    exp_have = 1'b1;
    tick();
    req_valid = 1'b0;
    req_a = ~a; req_b = ~b; req_ci = ~ci; req_op = ~op;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    chk("rsp_timeout", rsp_valid, 1);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_have  = 1'b0;
    chk("post_hs_req_ready", req_ready, 1);
    chk("post_hs_rsp_valid", rsp_valid, 0);
  endtask

  task automatic run_op(input string name, input logic [8:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ci, input logic msb,
                        input logic [W-1:0] lit_res, input logic lit_co, input logic lit_z,
                        input logic lit_neg);
    issue(op, a, b, ci, msb);
    wait_rsp();
    chk({name, "_lit"}, {rsp_result, rsp_co, rsp_z, rsp_neg}, {lit_res, lit_co, lit_z, lit_neg});
    finish_rsp();
  endtask

  initial begin
    // Reset state.
    tick(); tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {rsp_result, rsp_co, rsp_z, rsp_neg}, 0);
    chk("rst_alu_drive", {alu_a_o, alu_acc_o, alu_ci_o, alu_op_o}, 0);
    reset = 1'b1;
    tick();

    // 0x00FF + 0x0001: the carry from the low byte feeds pass 1.
    issue(OP_ADD, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    chk("add1_p0_a", alu_a_o, 8'hFF);
    chk("add1_p0_ci", alu_ci_o, 0);
    chk("add1_busy", busy, 1);
    tick();
    chk("add1_p1_a", alu_a_o, 8'h00);
    chk("add1_p1_ci", alu_ci_o, 1);
    tick();
    chk("add1_valid_after_2", rsp_valid, 1);
    chk("add1_lit", {rsp_result, rsp_co, rsp_z, rsp_neg}, {16'h0100, 3'b000});
    finish_rsp();

    // The zero flag must come from both bytes.
    run_op("add_ffff", OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    // req_ci is used only in pass 0; neg comes from the MSB byte.
    run_op("add_ci", OP_ADD, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
    run_op("shl", OP_SHL, 16'h8001, 16'h0000, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0);
    run_op("unk_op", OP_UNK, 16'h1234, 16'h00FF, 1'b0, 1'b0, 16'h12CB, 1'b0, 1'b0, 1'b0);

    // MSB-first right shift: the high byte goes first.
    issue(OP_SHR, 16'h1234, 16'h0000, 1'b0, 1'b1);
    chk("shr_p0_a", alu_a_o, 8'h12);
    tick();
    chk("shr_p1_a", alu_a_o, 8'h34);
    tick();
    chk("shr_lit", {rsp_result, rsp_co, rsp_z, rsp_neg}, {16'h091A, 3'b000});
    finish_rsp();

    // Backpressure: hold for 5 cycles. A request pulse meanwhile is ignored.
    issue(OP_ADD, 16'h0102, 16'h0304, 1'b0, 1'b0);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      req_valid = (i == 2);
      tick();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_res", rsp_result, 16'h0406);
    end
    req_valid = 1'b0;
    finish_rsp();
    tick();
    chk("bp_no_accept", busy, 0);

    // Reset during the second RUN cycle drops the operation.
    issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    exp_have = 1'b0;
    tick();
    chk("rrun_state", {req_ready, rsp_valid, busy}, 3'b100);
    chk("rrun_flags", {rsp_result, rsp_co, rsp_z, rsp_neg}, 0);
    chk("rrun_alu", {alu_a_o, alu_acc_o, alu_ci_o, alu_op_o}, 0);
    reset = 1'b1;
    tick(); tick(); tick();
    chk("rrun_no_rsp", rsp_valid, 0);
    run_op("after_rst", OP_ADD, 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);

    // Reset in DONE with rsp_ready high: reset wins.
    issue(OP_ADD, 16'h00F0, 16'h0001, 1'b0, 1'b0);
    wait_rsp();
    reset = 1'b0;
    rsp_ready = 1'b1;
    tick();
    exp_have = 1'b0;
    chk("rdone_state", {req_ready, rsp_valid, busy}, 3'b100);
    chk("rdone_res", rsp_result, 0);
    reset = 1'b1;
    rsp_ready = 1'b0;
    tick();
    run_op("final", OP_ADD, 16'h0080, 16'h0080, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-byte operation sequencer for the 8-bit accumulator ALU.
- Accepts one wide operation (NBYTES×8 bits) over a valid/ready handshake and drives the combinational ALU one byte per cycle.
- Chains carry/shift-out (co → ci) between byte passes and merges per-byte flags.
- Returns the wide result over a valid/ready response channel. Sits between the issue stage and the shared ALU instance.

Parameters:
- NBYTES, 2, bytes per operation; legal range 1..4; operand width W = 8*NBYTES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-low (reset==0 at a rising edge resets).
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  9  ALU opcode, from the definitions package.
- req_a  in  W  operand A, routed to in_a.
- req_b  in  W  operand B, routed to in_acc.
- req_ci  in  1  carry/shift-in for the first byte pass.
- req_msb_first  in  1  0: byte order LSB→MSB (add/left shift); 1: MSB→LSB (right shift).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_result  out  W  wide result.
- rsp_co  out  1  carry out of the final byte pass.
- rsp_z  out  1  whole result is zero.
- rsp_neg  out  1  neg flag from the MSB byte pass.
- busy  out  1  state != IDLE.
- alu_a_o  out  8  to ALU in_a.
- alu_acc_o  out  8  to ALU in_acc.
- alu_ci_o  out  1  to ALU ci.
- alu_op_o  out  9  to ALU op.
- alu_acc_i  in  8  from ALU acc.
- alu_co_i  in  1  from ALU co.
- alu_z_i  in  1  from ALU z.
- alu_neg_i  in  1  from ALU neg.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_result 0, rsp_co 0, rsp_z 0, rsp_neg 0, busy 0, byte index 0. ALU drive outputs are 0 while IDLE.
- req_ready = (state==IDLE) only; it is combinational from state. No back-to-back overlap.
- IDLE: on req_valid & req_ready at edge E0, register op, a, b, ci and msb_first; clear the result register; set z_acc=1; set idx=0; go to RUN. Later changes on req_* are ignored.
- RUN, cycle for pass i (i = 0..NBYTES-1):
  - Byte k = i when LSB-first, NBYTES-1-i when MSB-first.
  - alu_a_o = A[k], alu_acc_o = B[k], alu_op_o = latched op.
  - alu_ci_o = latched ci for i==0, otherwise the carry register.
- At each RUN edge: result[k] <= alu_acc_i; carry <= alu_co_i; z_acc <= z_acc & alu_z_i; if k==NBYTES-1, neg <= alu_neg_i; idx++.
- After the pass with i==NBYTES-1, go to DONE. rsp_valid rises after edge E_NBYTES, so there are exactly NBYTES ALU cycles.
- DONE:
  - rsp_valid=1.
  - rsp_co = final carry, rsp_z = z_acc, rsp_neg = captured neg.
  - rsp_result and all flags are held stable until the handshake.
  - On rsp_valid & rsp_ready → IDLE, with req_ready=1 the next cycle.
- rsp_ready low in DONE: stall indefinitely, no change to outputs.
- NBYTES==1: RUN lasts one cycle. msb_first has no effect.
- Reset low in any state, including mid-RUN or in DONE with rsp_ready high at the same edge: reset wins. Go to IDLE with reset values; the in-flight operation is dropped and no response is produced.
- Unknown opcodes are passed through unchanged. The sequencer does not decode op.

Test Plan:
- NBYTES=2, ADD, a=0x00FF, b=0x0001, ci=0, LSB-first → after 2 RUN cycles rsp_result=0x0100, co=0, z=0, neg=0. alu_ci_o in pass 1 = 1 (carry from 0xFF+0x01).
- ADD, a=0xFFFF, b=0x0001, ci=0 → rsp_result=0x0000, co=1, z=1, neg=0. Per-byte z combines correctly; the low byte's z alone is insufficient.
- ADD, a=0x7FFF, b=0x0000, ci=1 → rsp_result=0x8000, co=0, z=0, neg=1. Carry-in from req_ci is used only in pass 0.
- Backpressure: complete an op with rsp_ready=0 for 5 cycles → rsp_valid stays 1 and the result is stable. req_ready=0 throughout, and a req_valid pulse in that window is not accepted. Raise rsp_ready → IDLE on the next edge.
- reset=0 during the second RUN cycle → next cycle state IDLE, rsp_valid=0, all outputs at reset values. A new request after reset=1 completes normally.
- req_msb_first=1, SHL-class op or any op, a=0x1234 → alu_a_o shows 0x12 then 0x34 across the two passes, and rsp_result bytes land at the correct positions.
